// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   PARITY_*       : parity mode encodings for the PARITY parameter
//   rx_state_e     : receiver FSM states
//   frame_bits()   : bit periods per frame for a given format
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX input conditioning: 2-FF synchroniser plus 3-sample majority vote.
//   clk, rst   : clock, synchronous active-high reset
//   rx_i       : asynchronous serial input (idle high)
//   cnt_i      : bit-period counter from the receiver FSM
//   rx_s_o     : synchronised rx
//   bit_val_o  : majority of samples at cnt = MID-1, MID and the current
//                rx_s; meaningful in the cycle where cnt == MID+1
module uart_rx_sampler #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_i,
  input  logic [$clog2(CLKS_PER_BIT)-1:0] cnt_i,
  output logic                            rx_s_o,
  output logic                            bit_val_o
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_S0 = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1 = CW'(MID);

  logic meta_q;
  logic rx_s_q;
  logic smp0_q;
  logic smp1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      smp0_q <= 1'b1;
      smp1_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      rx_s_q <= meta_q;
      if (cnt_i == CNT_S0) smp0_q <= rx_s_q;
      if (cnt_i == CNT_S1) smp1_q <= rx_s_q;
    end
  end

  // Third sample is the live rx_s at cnt == MID+1, so the vote is ready
  // in that same cycle without an extra register stage.
  assign bit_val_o = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
  assign rx_s_o    = rx_s_q;

endmodule

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity,
// 1 or 2 stop bits) with valid/ready output handshake.
//   clk, rst    : clock, synchronous active-high reset
//   rx          : asynchronous serial input, idle high
//   rx_data     : received word (LSB first on the wire)
//   rx_valid    : rx_data and status flags valid
//   rx_ready    : consumer accepts when rx_valid && rx_ready
//   parity_err  : parity mismatch for the word in rx_data
//   frame_err   : a stop bit sampled 0
//   break_det   : data, parity and first stop bit all 0
//   overrun     : 1-cycle pulse when a completed frame is dropped
//   busy        : FSM not in IDLE
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW  = $clog2(DATA_BITS);
  localparam int unsigned MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam bit HAS_PAR  = (PARITY != PARITY_NONE);
  localparam bit PAR_ODD  = (PARITY == PARITY_ODD);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 brk_q, brk_d;
  logic                 stop2_q, stop2_d;
  logic                 commit_q, commit_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_out_q, brk_out_d;
  logic                 overrun_q, overrun_d;

  logic rx_s;
  logic bit_val;
  logic dec;
  logic last;
  logic ferr_next;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx),
    .cnt_i    (cnt_q),
    .rx_s_o   (rx_s),
    .bit_val_o(bit_val)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    zero_d    = zero_q;
    brk_d     = brk_q;
    stop2_d   = stop2_q;
    commit_d  = 1'b0;
    ferr_next = ferr_q;
    dec       = (cnt_q == CNT_DEC);
    last      = (cnt_q == CNT_LAST);
    cnt_d     = last ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          zero_d  = 1'b1;
          brk_d   = 1'b0;
          stop2_d = 1'b0;
        end
      end
      S_START: begin
        if (dec && bit_val) begin
          state_d = S_IDLE;
        end else if (last) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (dec) begin
          data_d[idx_q] = bit_val;
          zero_d        = zero_q & ~bit_val;
        end
        if (last) begin
          if (idx_q == IDX_LAST) state_d = HAS_PAR ? S_PARITY : S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (dec) begin
          perr_d = (((^data_q) ^ bit_val) != PAR_ODD);
          zero_d = zero_q & ~bit_val;
        end
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (dec) begin
          ferr_next = ferr_q | ~bit_val;
          ferr_d    = ferr_next;
          if (!stop2_q) brk_d = zero_q & ~bit_val;
          // Commit on the last stop bit's decision, not its period end,
          // so a following start edge is never missed.
          if (!TWO_STOP || stop2_q) begin
            commit_d = 1'b1;
            state_d  = ferr_next ? S_WAIT_IDLE : S_IDLE;
          end
        end else if (last && TWO_STOP) begin
          stop2_d = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    brk_out_d  = brk_out_q;
    overrun_d  = 1'b0;
    if (commit_q) begin
      if (!valid_q || rx_ready) begin
        rx_data_d  = data_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q;
        brk_out_d  = brk_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      brk_q      <= 1'b0;
      stop2_q    <= 1'b0;
      commit_q   <= 1'b0;
      rx_data_q  <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      brk_q      <= brk_d;
      stop2_q    <= stop2_d;
      commit_q   <= commit_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      brk_out_q  <= brk_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_out_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8N1 instance and a 7E2 instance,
// both at 16 clocks per bit.
module tb_uart_rx_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rx8 = 1'b1, rdy8 = 1'b1;
  logic [7:0] data8;
  logic       v8, pe8, fe8, bd8, ov8, busy8;

  logic       rx7 = 1'b1, rdy7 = 1'b1;
  logic [6:0] data7;
  logic       v7, pe7, fe7, bd7, ov7, busy7;

  uart_rx_ext #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_data(data8), .rx_valid(v8), .rx_ready(rdy8),
    .parity_err(pe8), .frame_err(fe8), .break_det(bd8), .overrun(ov8), .busy(busy8));

  uart_rx_ext #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .rx_data(data7), .rx_valid(v7), .rx_ready(rdy7),
    .parity_err(pe7), .frame_err(fe7), .break_det(bd7), .overrun(ov7), .busy(busy7));

  int total = 0;
  int bad   = 0;

  // Monitors: latch each newly presented word and count activity.
  int         n8 = 0, vc8 = 0, ovc8 = 0, n7 = 0;
  logic       pv8 = 1'b0, pv7 = 1'b0;
  logic [7:0] ld8 = '0;
  logic       lpe8 = 1'b0, lfe8 = 1'b0, lbd8 = 1'b0;
  logic [6:0] ld7 = '0;
  logic       lpe7 = 1'b0, lfe7 = 1'b0;

  always @(negedge clk) begin
    if (v8 && !pv8) begin
      n8++; ld8 = data8; lpe8 = pe8; lfe8 = fe8; lbd8 = bd8;
    end
    if (v8) vc8++;
    if (ov8) ovc8++;
    pv8 = v8;
    if (v7 && !pv7) begin
      n7++; ld7 = data7; lpe7 = pe7; lfe7 = fe7;
    end
    pv7 = v7;
  end

  task automatic bit8(input logic v);
    rx8 = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic bit7(input logic v);
    rx7 = v;
    repeat (16) @(negedge clk);
  endtask

  // spike_bit >= 0 inverts rx for one clock in the middle of that bit.
  task automatic send8(input logic [7:0] d, input logic stopv, input int spike_bit);
    bit8(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        rx8 = d[i];
        repeat (8) @(negedge clk);
        rx8 = ~d[i];
        @(negedge clk);
        rx8 = d[i];
        repeat (7) @(negedge clk);
      end else begin
        bit8(d[i]);
      end
    end
    bit8(stopv);
  endtask

  task automatic send7(input logic [6:0] d, input logic p);
    bit7(1'b0);
    for (int i = 0; i < 7; i++) bit7(d[i]);
    bit7(p);
    bit7(1'b1);
    bit7(1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (v8 !== 1'b0) begin bad++; $display("FAIL reset_valid8 got=%b exp=0", v8); end
    total++; if (data8 !== 8'h00) begin bad++; $display("FAIL reset_data8 got=%h exp=00", data8); end
    total++; if ({pe8, fe8, bd8, ov8} !== 4'b0000) begin bad++; $display("FAIL reset_flags8 got=%b exp=0000", {pe8, fe8, bd8, ov8}); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    total++; if ({v7, busy7, pe7, fe7} !== 4'b0000) begin bad++; $display("FAIL reset_dut7 got=%b exp=0000", {v7, busy7, pe7, fe7}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1;
    int bn, bv;
    bn = n8; bv = vc8;
    rdy8 = 1'b1;
    send8(8'hA5, 1'b1, -1);
    repeat (16) @(negedge clk);
    total++; if (n8 - bn !== 1) begin bad++; $display("FAIL 8n1_count got=%0d exp=1", n8 - bn); end
    total++; if (ld8 !== 8'hA5) begin bad++; $display("FAIL 8n1_data got=%h exp=a5", ld8); end
    total++; if ({lpe8, lfe8, lbd8} !== 3'b000) begin bad++; $display("FAIL 8n1_flags got=%b exp=000", {lpe8, lfe8, lbd8}); end
    total++; if (vc8 - bv !== 1) begin bad++; $display("FAIL 8n1_valid_cycles got=%0d exp=1", vc8 - bv); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL 8n1_busy got=%b exp=0", busy8); end
  endtask

  task automatic test_7e2_parity;
    int bn;
    bn = n7;
    send7(7'h35, 1'b0);
    repeat (16) @(negedge clk);
    total++; if (ld7 !== 7'h35) begin bad++; $display("FAIL 7e2_data_a got=%h exp=35", ld7); end
    total++; if (lpe7 !== 1'b0) begin bad++; $display("FAIL 7e2_perr_a got=%b exp=0", lpe7); end
    total++; if (lfe7 !== 1'b0) begin bad++; $display("FAIL 7e2_ferr_a got=%b exp=0", lfe7); end
    send7(7'h35, 1'b1);
    repeat (16) @(negedge clk);
    total++; if (ld7 !== 7'h35) begin bad++; $display("FAIL 7e2_data_b got=%h exp=35", ld7); end
    total++; if (lpe7 !== 1'b1) begin bad++; $display("FAIL 7e2_perr_b got=%b exp=1", lpe7); end
    total++; if (n7 - bn !== 2) begin bad++; $display("FAIL 7e2_count got=%0d exp=2", n7 - bn); end
  endtask

  task automatic test_frame_err;
    int bn;
    bn = n8;
    send8(8'h55, 1'b0, -1);
    repeat (16) @(negedge clk);
    total++; if (ld8 !== 8'h55) begin bad++; $display("FAIL ferr_data got=%h exp=55", ld8); end
    total++; if ({lfe8, lbd8} !== 2'b10) begin bad++; $display("FAIL ferr_flags got=%b exp=10", {lfe8, lbd8}); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL ferr_busy_low got=%b exp=1", busy8); end
    rx8 = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL ferr_busy_high got=%b exp=0", busy8); end
    total++; if (n8 - bn !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", n8 - bn); end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_break;
    int bn;
    bn = n8;
    rx8 = 1'b0;
    repeat (20 * 16) @(negedge clk);
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL brk_busy got=%b exp=1", busy8); end
    rx8 = 1'b1;
    repeat (32) @(negedge clk);
    total++; if (n8 - bn !== 1) begin bad++; $display("FAIL brk_count got=%0d exp=1", n8 - bn); end
    total++; if (ld8 !== 8'h00) begin bad++; $display("FAIL brk_data got=%h exp=00", ld8); end
    total++; if ({lfe8, lbd8} !== 2'b11) begin bad++; $display("FAIL brk_flags got=%b exp=11", {lfe8, lbd8}); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL brk_idle got=%b exp=0", busy8); end
  endtask

  task automatic test_glitch;
    int bn;
    bn = n8;
    rx8 = 1'b0;
    repeat (3) @(negedge clk);
    rx8 = 1'b1;
    repeat (48) @(negedge clk);
    total++; if (n8 - bn !== 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", n8 - bn); end
    total++; if ({v8, busy8} !== 2'b00) begin bad++; $display("FAIL glitch_state got=%b exp=00", {v8, busy8}); end
  endtask

  task automatic test_spike;
    int bn;
    bn = n8;
    send8(8'hC3, 1'b1, 3);
    repeat (16) @(negedge clk);
    total++; if (n8 - bn !== 1) begin bad++; $display("FAIL spike_count got=%0d exp=1", n8 - bn); end
    total++; if (ld8 !== 8'hC3) begin bad++; $display("FAIL spike_data got=%h exp=c3", ld8); end
    total++; if (lfe8 !== 1'b0) begin bad++; $display("FAIL spike_ferr got=%b exp=0", lfe8); end
  endtask

  task automatic test_overrun;
    int bn, bo;
    bn = n8; bo = ovc8;
    rdy8 = 1'b0;
    send8(8'h11, 1'b1, -1);
    repeat (16) @(negedge clk);
    send8(8'h22, 1'b1, -1);
    repeat (16) @(negedge clk);
    total++; if (v8 !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", v8); end
    total++; if (data8 !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", data8); end
    total++; if (ovc8 - bo !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovc8 - bo); end
    total++; if (n8 - bn !== 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", n8 - bn); end
    rdy8 = 1'b1;
    @(negedge clk);
    total++; if (v8 !== 1'b0) begin bad++; $display("FAIL ovr_drop got=%b exp=0", v8); end
    send8(8'h33, 1'b1, -1);
    repeat (16) @(negedge clk);
    total++; if (ld8 !== 8'h33) begin bad++; $display("FAIL ovr_next_data got=%h exp=33", ld8); end
    total++; if (n8 - bn !== 2) begin bad++; $display("FAIL ovr_next_count got=%0d exp=2", n8 - bn); end
  endtask

  task automatic test_reset_mid;
    int bn;
    logic [7:0] d;
    d = 8'h7E;
    bit8(1'b0);
    for (int i = 0; i < 4; i++) bit8(d[i]);
    rx8 = d[4];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({v8, busy8, pe8, fe8, bd8, ov8} !== 6'b0) begin bad++; $display("FAIL rmid_outs got=%b exp=000000", {v8, busy8, pe8, fe8, bd8, ov8}); end
    total++; if (data8 !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", data8); end
    rst = 1'b0;
    bn = n8;
    rx8 = 1'b1;
    repeat (64) @(negedge clk);
    total++; if (n8 - bn !== 0) begin bad++; $display("FAIL rmid_nocommit got=%0d exp=0", n8 - bn); end
    send8(8'h7E, 1'b1, -1);
    repeat (16) @(negedge clk);
    total++; if (n8 - bn !== 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", n8 - bn); end
    total++; if (ld8 !== 8'h7E) begin bad++; $display("FAIL rmid_data_next got=%h exp=7e", ld8); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_7e2_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_spike();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised successor UART receiver with configurable frame format: 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits.
- Adds a 2-FF input synchroniser, 3-sample majority voting, and a valid/ready output handshake.
- Reports parity, framing, break and overrun conditions.
- Sits between the board RX pin and byte-consuming logic (command parser, FIFO).

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit period; must be >= 4.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received word, LSB first on the wire
- rx_valid  out  1  rx_data and its status flags are valid
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
- parity_err  out  1  parity mismatch for the word in rx_data; 0 when PARITY=0
- frame_err  out  1  a stop bit was sampled 0 for this word
- break_det  out  1  all data bits, the parity bit (if present) and the first stop bit were 0
- overrun  out  1  1-cycle pulse: a completed frame was dropped
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0, and both synchroniser flops are 1.
- Synchroniser: rx passes through 2 flops to give rx_s, so there are 2 cycles of input latency.
- Counters:
  - cnt is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1 per bit period.
  - MID = CLKS_PER_BIT/2.
- Sampling:
  - rx_s is sampled at cnt = MID-1, MID and MID+1.
  - The bit value is the majority of the 3 samples, decided in the cycle where cnt == MID+1.
- States:
  - IDLE: when rx_s == 0, set cnt = 0 and go to START.
  - START:
    - Majority is 1 at the decision point: false start, return to IDLE.
    - Otherwise, at cnt == CLKS_PER_BIT-1, go to DATA with bit index 0.
  - DATA:
    - Each decision shifts the bit into data_reg[idx].
    - At period end: if idx == DATA_BITS-1, go to PARITY (PARITY != 0) or STOP; otherwise idx++.
  - PARITY:
    - Decision computes err = (XOR of data ^ parity bit) != (PARITY == 1).
    - In other words, odd parity expects the total XOR to be 1, and even parity expects 0.
    - At period end, go to STOP.
  - STOP:
    - A decision of 0 sets the frame-error flag.
    - If STOP_BITS == 2, the first stop bit runs to period end and the second stop bit is decided the same way.
    - The frame commits at the decision point of the last stop bit, not at period end; this allows early resync.
    - After commit: frame error set goes to WAIT_IDLE, otherwise to IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents retriggering during a break.
- Commit, in the cycle after the decision point:
  - If rx_valid == 0, or rx_valid && rx_ready in the commit cycle:
    - Load rx_data, parity_err, frame_err and break_det.
    - Set rx_valid = 1.
  - Otherwise the frame is dropped, old data and flags are held, and overrun pulses for 1 cycle.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready, unless a commit occurs in that same cycle.
  - Status flags stay registered with rx_data until the next load.
- Break: break_det implies frame_err = 1.
- Reset mid-frame: the frame is abandoned and there is no commit; after reset the block resumes in IDLE.
- Frame length: 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods.

Decomposition:
- Shared package uart_pkg contains:
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants.
  - The rx state enum: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - A helper function that returns the frame length in bits.
- One sub-module, uart_rx_sampler, contains the 2-FF synchroniser and the 3-sample majority logic. Its inputs are rx and cnt; its outputs are rx_s and bit_val.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
- 8N1: send 0xA5 with rx_ready = 1 → rx_data = 0xA5, rx_valid high 1 cycle, all flags 0, single commit.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: send 0x35 with parity 0 → parity_err = 0. Resend with parity 1 → parity_err = 1, rx_data = 0x35.
- Framing error and break:
  - Send 0x55 with stop bit 0 → frame_err = 1, break_det = 0, and busy stays high until rx returns high.
  - Hold rx low for 20 bit times → one word 0x00 with break_det = 1 and frame_err = 1, and no second frame.
- Glitch and noise:
  - A 3-cycle low glitch on idle rx → no frame and rx_valid stays 0.
  - A 1-cycle inverted spike at the MID of bit 3 → the received byte is still correct.
- Overrun: hold rx_ready = 0 and send 0x11 then 0x22 → rx_data = 0x11 and overrun pulses once. Then assert rx_ready → rx_valid drops and the next frame 0x33 is received.
- Reset mid-frame: assert rst during DATA bit 4 for 1 cycle → outputs are 0, and the next clean frame 0x7E is received correctly.
